// File: rtl/timer_pkg.sv
// Shared encodings for the timer bank channel: counting modes and FSM states.
package timer_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_FREERUN  = 2'b10,
        MODE_RSVD     = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/timer_bank_channel.sv
// One timer channel: up/down counter toward a latched terminal value with
// one-shot, periodic-reload and free-run behaviour and a terminal pulse.
module timer_bank_channel
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter logic [1:0]  RESET_MODE = 2'b00
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             hold,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] count,
    output logic             count_reached,
    output logic             done,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] term_q, term_d;
    mode_e            mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             reached_q, reached_d;

    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] step_val;
    mode_e            mode_eff;

    // Target and reload value follow the direction latched at start.
    assign target    = dir_q ? '0 : term_q;
    assign start_val = dir_q ? term_q : '0;
    assign step_val  = dir_q ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
    assign mode_eff  = (mode == MODE_RSVD) ? mode_e'(RESET_MODE) : mode_e'(mode);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        term_d    = term_q;
        mode_d    = mode_q;
        dir_d     = dir_q;
        reached_d = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (start) begin
            term_d  = term_val;
            mode_d  = mode_eff;
            dir_d   = dir;
            count_d = dir ? term_val : '0;
            state_d = ST_RUN;
        end else if (stop) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_RUN && !hold) begin
            if (count_q == target) begin
                reached_d = 1'b1;
                case (mode_q)
                    MODE_PERIODIC: count_d = start_val;
                    MODE_FREERUN:  count_d = step_val;
                    default:       state_d = ST_DONE;
                endcase
            end else begin
                count_d = step_val;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            term_q    <= '0;
            mode_q    <= MODE_ONESHOT;
            dir_q     <= 1'b0;
            reached_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            term_q    <= term_d;
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            reached_q <= reached_d;
        end
    end

    assign count         = count_q;
    assign count_reached = reached_q;
    assign done          = (state_q == ST_DONE);
    assign busy          = (state_q == ST_RUN);

endmodule

// File: tb/tb_timer_bank_channel.sv
// Directed bench for timer_bank_channel at WIDTH=8; a second instance uses
// RESET_MODE=01 so the reserved mode encoding can be checked as periodic.
module tb_timer_bank_channel;

    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic       start = 1'b0, stop = 1'b0, clear = 1'b0, hold = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       dir = 1'b0;
    logic [7:0] term_val = 8'd0;

    logic [7:0] count0, count1;
    logic       reached0, reached1, done0, done1, busy0, busy1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    timer_bank_channel #(.WIDTH(8)) dut0 (
        .clk(clk), .reset_b(reset_b), .start(start), .stop(stop), .clear(clear),
        .hold(hold), .mode(mode), .dir(dir), .term_val(term_val),
        .count(count0), .count_reached(reached0), .done(done0), .busy(busy0)
    );

    timer_bank_channel #(.WIDTH(8), .RESET_MODE(2'b01)) dut1 (
        .clk(clk), .reset_b(reset_b), .start(start), .stop(stop), .clear(clear),
        .hold(hold), .mode(mode), .dir(dir), .term_val(term_val),
        .count(count1), .count_reached(reached1), .done(done1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] m, input logic d, input logic [7:0] t);
        mode = m; dir = d; term_val = t; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_oneshot5();
        do_start(2'b00, 1'b0, 8'd5);
        check("os_start_count", count0, 0);
        check("os_start_busy", busy0, 1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("os_count", count0, i);
            check("os_no_pulse", reached0, 0);
        end
        tick();
        check("os_pulse", reached0, 1);
        check("os_done", done0, 1);
        check("os_busy_low", busy0, 0);
        check("os_hold5", count0, 5);
        // inputs other than start/stop/clear ignored in DONE
        hold = 1'b1; mode = 2'b10; dir = 1'b1; term_val = 8'd99;
        tick();
        hold = 1'b0;
        check("os_pulse_once", reached0, 0);
        check("os_done_persist", done0, 1);
        check("os_count_persist", count0, 5);
    endtask

    task automatic run_periodic_down3(input logic [1:0] m, input logic use_dut1);
        logic [7:0] exp_cnt;
        logic       exp_r;
        logic [7:0] c;
        logic       r, b;
        do_start(m, 1'b1, 8'd3);
        exp_cnt = 8'd3;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (exp_cnt == 8'd0) begin exp_cnt = 8'd3; exp_r = 1'b1; end
            else begin exp_cnt = exp_cnt - 8'd1; exp_r = 1'b0; end
            c = use_dut1 ? count1 : count0;
            r = use_dut1 ? reached1 : reached0;
            b = use_dut1 ? busy1 : busy0;
            check("per_count", c, exp_cnt);
            check("per_pulse", r, exp_r);
            check("per_busy", b, 1);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        c = use_dut1 ? count1 : count0;
        r = use_dut1 ? reached1 : reached0;
        b = use_dut1 ? busy1 : busy0;
        check("per_stop_busy", b, 0);
        check("per_stop_count", c, exp_cnt);
        check("per_stop_pulse", r, 0);
    endtask

    initial begin
        int unsigned pulses;

        #2;
        check("rst_count", count0, 0);
        check("rst_pulse", reached0, 0);
        check("rst_done", done0, 0);
        check("rst_busy", busy0, 0);
        #10 reset_b = 1'b1;
        tick();
        check("idle_busy", busy0, 0);

        run_oneshot5();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("done_stop_done", done0, 0);
        check("done_stop_count", count0, 5);

        run_periodic_down3(2'b01, 1'b0);
        run_periodic_down3(2'b01, 1'b1);
        // reserved encoding: dut1 treats it as periodic, dut0 as one-shot
        run_periodic_down3(2'b11, 1'b1);
        do_start(2'b11, 1'b0, 8'd2);
        tick(); tick(); tick();
        check("rsvd_dut0_done", done0, 1);
        check("rsvd_dut1_busy", busy1, 1);
        check("rsvd_dut1_count", count1, 0);

        do_start(2'b10, 1'b0, 8'd255);
        check("fr_start", count0, 0);
        pulses = 0;
        for (int i = 1; i <= 256; i++) begin
            tick();
            check("fr_count", count0, i % 256);
            if (reached0) pulses++;
        end
        check("fr_wrap_pulse", reached0, 1);
        check("fr_pulses", pulses, 1);
        for (int i = 1; i <= 255; i++) tick();
        check("fr_at_term", count0, 255);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("fr_hold_count", count0, 255);
            check("fr_hold_pulse", reached0, 0);
        end
        hold = 1'b0;
        tick();
        check("fr_release_count", count0, 0);
        check("fr_release_pulse", reached0, 1);

        do_start(2'b00, 1'b0, 8'd0);
        tick();
        check("t0_pulse", reached0, 1);
        check("t0_done", done0, 1);
        do_start(2'b01, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t0_per_pulse", reached0, 1);
            check("t0_per_count", count0, 0);
        end
        do_start(2'b00, 1'b0, 8'd5);
        tick(); tick(); tick();
        check("pre_clear_count", count0, 3);
        start = 1'b1; clear = 1'b1;
        tick();
        start = 1'b0; clear = 1'b0;
        check("clr_count", count0, 0);
        check("clr_busy", busy0, 0);
        check("clr_done", done0, 0);
        check("clr_pulse", reached0, 0);

        do_start(2'b00, 1'b0, 8'd10);
        for (int i = 0; i < 7; i++) tick();
        check("pre_rst_count", count0, 7);
        #2 reset_b = 1'b0;
        #1;
        check("arst_count", count0, 0);
        check("arst_busy", busy0, 0);
        check("arst_done", done0, 0);
        check("arst_pulse", reached0, 0);
        #1 reset_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_pulse", reached0, 0);
            check("post_rst_busy", busy0, 0);
            check("post_rst_count", count0, 0);
        end
        run_oneshot5();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
